// File: rtl/h2f_regread_arbiter.sv
// Round-robin arbiter that shares the register bank's single combinational read port
// among NUM_REQ fabric clients, returning one registered word per granted request.
module h2f_regread_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TOTREG    = 32,
  parameter int DATAWIDTH = 64,
  localparam int SELW     = $clog2(TOTREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*SELW-1:0]   req_sel_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATAWIDTH-1:0]      rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [SELW-1:0]           regsel_o,
  input  logic [DATAWIDTH-1:0]      regdata_i
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [SELW:0] TOTREG_LIM = (SELW+1)'(TOTREG);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   last_winner;
  logic [IDXW-1:0]   winner;
  logic [NUM_REQ-1:0] eligible;
  logic              found;

  function automatic logic in_range(input logic [SELW-1:0] sel);
    return {1'b0, sel} < TOTREG_LIM;
  endfunction

  assign busy_o = (state == READ);

  // Arbitration: the client being answered this cycle is masked so a held
  // request cannot win back-to-back against itself.
  always_comb begin
    eligible  = req_i & ~rvalid_o;
    winner    = last_winner;
    found     = 1'b0;
    state_nxt = state;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && eligible[(int'(last_winner) + i) % NUM_REQ]) begin
        winner = IDXW'((int'(last_winner) + i) % NUM_REQ);
        found  = 1'b1;
      end
    end
    case (state)
      IDLE:    if (found) state_nxt = READ;
      READ:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant / capture stage
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_o       <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      regsel_o    <= '0;
      last_winner <= IDXW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          rvalid_o <= '0;
          err_o    <= 1'b0;
          if (found) begin
            gnt_o       <= NUM_REQ'(1) << winner;
            regsel_o    <= req_sel_i[winner*SELW +: SELW];
            last_winner <= winner;
          end else begin
            gnt_o <= '0;
          end
        end
        READ: begin
          gnt_o <= '0;
          if ((req_i & gnt_o) != '0) begin
            rvalid_o <= gnt_o;
            if (in_range(regsel_o)) begin
              rdata_o <= regdata_i;
              err_o   <= 1'b0;
            end else begin
              rdata_o <= '0;
              err_o   <= 1'b1;
            end
          end else begin
            rvalid_o <= '0;
            err_o    <= 1'b0;
          end
        end
        default: begin
          gnt_o    <= '0;
          rvalid_o <= '0;
          err_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h2f_regread_arbiter.sv
// Directed bench for h2f_regread_arbiter with a combinational register-bank model
// (TOTREG=24 so out-of-range indexes are reachable).
module tb_h2f_regread_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int TOTREG    = 24;
  localparam int DATAWIDTH = 64;
  localparam int SELW      = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*SELW-1:0] sel;
  logic [NUM_REQ-1:0]      gnt, rvalid;
  logic [DATAWIDTH-1:0]    rdata, regdata;
  logic                    err, busy;
  logic [SELW-1:0]         regsel;
  logic [DATAWIDTH-1:0]    bank [0:31];

  int tests  = 0;
  int failed = 0;

  h2f_regread_arbiter #(
    .NUM_REQ(NUM_REQ), .TOTREG(TOTREG), .DATAWIDTH(DATAWIDTH)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_sel_i(sel),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .busy_o(busy), .regsel_o(regsel), .regdata_i(regdata)
  );

  always #5 clk = ~clk;

  assign regdata = bank[regsel];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input int k, input logic [SELW-1:0] v);
    sel[k*SELW +: SELW] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},    64'(gnt),    64'h0);
    check({tag, "_rvalid"}, 64'(rvalid), 64'h0);
    check({tag, "_rdata"},  rdata,       64'h0);
    check({tag, "_err"},    64'(err),    64'h0);
    check({tag, "_busy"},   64'(busy),   64'h0);
    check({tag, "_regsel"}, 64'(regsel), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      bank[i] = 64'h0BAD_F00D_0000_0000 + 64'(i) * 64'h0001_0001_0001_0001;
    bank[5] = 64'hDEAD_BEEF_0123_4567;

    rst = 1'b1; req = '0; sel = '0;
    tick(); tick();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Single read of reg5 by client 0
    req = 4'b0001; set_sel(0, 5'd5);
    tick();
    check("t1_gnt",    64'(gnt),    64'h1);
    check("t1_busy",   64'(busy),   64'h1);
    check("t1_regsel", 64'(regsel), 64'd5);
    tick();
    check("t1_rvalid", 64'(rvalid), 64'h1);
    check("t1_rdata",  rdata,       64'hDEAD_BEEF_0123_4567);
    check("t1_err",    64'(err),    64'h0);
    check("t1_gnt0",   64'(gnt),    64'h0);
    check("t1_busy0",  64'(busy),   64'h0);
    req = '0;
    tick();
    check("t1_rvalid_clr", 64'(rvalid), 64'h0);
    check("t1_gnt_idle",   64'(gnt),    64'h0);

    // Contention from reset: order 0,1,2,3,0,1,2,3
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    set_sel(0, 5'd1); set_sel(1, 5'd2); set_sel(2, 5'd3); set_sel(3, 5'd4);
    for (int g = 0; g < 8; g++) begin
      tick();
      check($sformatf("t2_gnt%0d", g),    64'(gnt),    64'(1) << (g % 4));
      check($sformatf("t2_regsel%0d", g), 64'(regsel), 64'((g % 4) + 1));
      tick();
      check($sformatf("t2_rvalid%0d", g), 64'(rvalid), 64'(1) << (g % 4));
      check($sformatf("t2_rdata%0d", g),  rdata,       bank[(g % 4) + 1]);
    end
    req = '0;
    tick();

    // Abort by client 2, then client 3 wins over client 0
    req = 4'b0100; set_sel(2, 5'd7);
    tick();
    check("t3_gnt2", 64'(gnt), 64'h4);
    req = 4'b1001; set_sel(0, 5'd9); set_sel(3, 5'd8);
    tick();
    check("t3_abort_rvalid", 64'(rvalid), 64'h0);
    check("t3_abort_rdata",  rdata,       bank[4]);
    check("t3_abort_gnt",    64'(gnt),    64'h0);
    tick();
    check("t3_gnt3",   64'(gnt),    64'h8);
    check("t3_regsel", 64'(regsel), 64'd8);
    set_sel(3, 5'd15);
    tick();
    check("t3_rvalid3", 64'(rvalid), 64'h8);
    check("t3_rdata3",  rdata,       bank[8]);
    req = 4'b0001;
    tick();
    check("t3_gnt0", 64'(gnt), 64'h1);
    tick();
    check("t3_rdata0", rdata, bank[9]);
    req = '0;
    tick();

    // Out-of-range index, then an in-range read clears err
    req = 4'b0010; set_sel(1, 5'd30);
    tick();
    check("t4_gnt", 64'(gnt), 64'h2);
    tick();
    check("t4_rvalid", 64'(rvalid), 64'h2);
    check("t4_err",    64'(err),    64'h1);
    check("t4_rdata",  rdata,       64'h0);
    set_sel(1, 5'd6);
    tick();
    check("t4_rvalid_clr", 64'(rvalid), 64'h0);
    check("t4_err_clr",    64'(err),    64'h0);
    check("t4_masked_gnt", 64'(gnt),    64'h0);
    tick();
    check("t4_gnt_again", 64'(gnt),    64'h2);
    check("t4_regsel",    64'(regsel), 64'd6);
    tick();
    check("t4_rvalid2", 64'(rvalid), 64'h2);
    check("t4_err2",    64'(err),    64'h0);
    check("t4_rdata2",  rdata,       bank[6]);
    req = '0;
    tick();

    // Reset during READ, then client 0 granted first
    req = 4'b0100; set_sel(2, 5'd10);
    tick();
    check("t5_gnt", 64'(gnt), 64'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("t5_rst");
    req = 4'b0011; set_sel(0, 5'd11); set_sel(1, 5'd12);
    tick();
    check("t5_gnt0", 64'(gnt), 64'h1);
    tick();
    check("t5_rvalid0", 64'(rvalid), 64'h1);
    check("t5_rdata0",  rdata,       bank[11]);
    req = 4'b0010;
    tick();
    check("t5_gnt1", 64'(gnt), 64'h2);
    tick();
    check("t5_rdata1", rdata, bank[12]);
    req = '0;
    tick();

    // Client 1 holds req past rvalid while client 3 requests
    req = 4'b0010; set_sel(1, 5'd13);
    tick();
    check("t6_gnt1", 64'(gnt), 64'h2);
    req = 4'b1010; set_sel(3, 5'd14);
    tick();
    check("t6_rvalid1", 64'(rvalid), 64'h2);
    check("t6_rdata1",  rdata,       bank[13]);
    tick();
    check("t6_gnt3", 64'(gnt), 64'h8);
    req = 4'b1000;
    tick();
    check("t6_rvalid3", 64'(rvalid), 64'h8);
    check("t6_rdata3",  rdata,       bank[14]);
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
